// File: rtl/reg_bus_cut.sv
// reg_bus_cut: registered cut for the single-phase register bus.
//
// Sits between a bus master and a register slave and breaks every
// combinational path in both directions. Each transaction walks the
// states IDLE -> REQ -> RSP. The upstream request is captured in IDLE,
// presented downstream from flops in REQ, and the captured response is
// returned upstream for exactly one cycle in RSP.
//
// An optional watchdog (TIMEOUT > 0) ends a REQ phase that has waited
// TIMEOUT cycles. The transaction then completes upstream with error=1
// and rdata=0.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   in_*_i / in_*_o     upstream side (master-facing)
//   out_*_o / out_*_i   downstream side (slave-facing)
module reg_bus_cut #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // upstream
    input  logic [AW-1:0]     in_addr_i,
    input  logic              in_write_i,
    input  logic [DW-1:0]     in_wdata_i,
    input  logic [DW/8-1:0]   in_wstrb_i,
    input  logic              in_valid_i,
    output logic [DW-1:0]     in_rdata_o,
    output logic              in_error_o,
    output logic              in_ready_o,
    // downstream
    output logic [AW-1:0]     out_addr_o,
    output logic              out_write_o,
    output logic [DW-1:0]     out_wdata_o,
    output logic [DW/8-1:0]   out_wstrb_o,
    output logic              out_valid_o,
    input  logic [DW-1:0]     out_rdata_i,
    input  logic              out_error_i,
    input  logic              out_ready_i
);

    localparam int SW = DW / 8;
    // $clog2(1) is 0, so keep at least one counter bit when the watchdog is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
    } rsp_t;

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    rsp_t          rsp_q, rsp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire;

    // The watchdog fires on the last permitted REQ cycle.
    // When TIMEOUT is 0 the leading term keeps it off.
    assign expire = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    req_d.addr  = in_addr_i;
                    req_d.write = in_write_i;
                    req_d.wdata = in_wdata_i;
                    req_d.wstrb = in_wstrb_i;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // A slave completion in the expiry cycle takes priority over the watchdog.
                if (out_ready_i) begin
                    rsp_d.rdata = out_rdata_i;
                    rsp_d.error = out_error_i;
                    state_d     = RSP;
                end else if (expire) begin
                    // The slave is treated as dead: out_valid_o drops without a handshake.
                    rsp_d.rdata = '0;
                    rsp_d.error = 1'b1;
                    state_d     = RSP;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output comes from a flop or is decoded from the state register.
    assign out_valid_o = (state_q == REQ);
    assign in_ready_o  = (state_q == RSP);
    assign out_addr_o  = req_q.addr;
    assign out_write_o = req_q.write;
    assign out_wdata_o = req_q.wdata;
    assign out_wstrb_o = req_q.wstrb;
    assign in_rdata_o  = rsp_q.rdata;
    assign in_error_o  = rsp_q.error;

endmodule

// File: tb/tb_reg_bus_cut.sv
module tb_reg_bus_cut;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared upstream fields and slave response
    logic [AW-1:0] addr = '0;
    logic          write = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic [DW-1:0] s_rdata = '0;
    logic          s_error = 1'b0;
    logic          echo = 1'b0;
    logic          v0 = 1'b0, r0 = 1'b0, v4 = 1'b0, r4 = 1'b0;

    // dut0: TIMEOUT=0 (a_*), dut4: TIMEOUT=4 (b_*)
    logic [DW-1:0] a_rdata, b_rdata, a_owdata, b_owdata, b_slv_rdata;
    logic          a_error, b_error, a_ready, b_ready, a_valid, b_valid;
    logic          a_owrite, b_owrite;
    logic [AW-1:0] a_oaddr, b_oaddr;
    logic [SW-1:0] a_owstrb, b_owstrb;

    // In echo mode the slave model answers with its address XOR a constant.
    assign b_slv_rdata = echo ? (b_oaddr ^ 32'hF0F0_0000) : s_rdata;

    reg_bus_cut #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_addr_i(addr), .in_write_i(write), .in_wdata_i(wdata), .in_wstrb_i(wstrb),
        .in_valid_i(v0), .in_rdata_o(a_rdata), .in_error_o(a_error), .in_ready_o(a_ready),
        .out_addr_o(a_oaddr), .out_write_o(a_owrite), .out_wdata_o(a_owdata),
        .out_wstrb_o(a_owstrb), .out_valid_o(a_valid),
        .out_rdata_i(s_rdata), .out_error_i(s_error), .out_ready_i(r0)
    );

    reg_bus_cut #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_addr_i(addr), .in_write_i(write), .in_wdata_i(wdata), .in_wstrb_i(wstrb),
        .in_valid_i(v4), .in_rdata_o(b_rdata), .in_error_o(b_error), .in_ready_o(b_ready),
        .out_addr_o(b_oaddr), .out_write_o(b_owrite), .out_wdata_o(b_owdata),
        .out_wstrb_o(b_owstrb), .out_valid_o(b_valid),
        .out_rdata_i(b_slv_rdata), .out_error_i(s_error), .out_ready_i(r4)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          q0[$];
    exp_t          q4[$];
    logic [AW-1:0] aq[$];
    int            errors = 0;
    int            checks = 0;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", b_ready); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", b_valid); end
        checks++; if (b_rdata !== '0) begin errors++; $display("FAIL reset_in_rdata got=%h exp=0", b_rdata); end
        checks++; if (b_error !== 1'b0) begin errors++; $display("FAIL reset_in_error got=%b exp=0", b_error); end
        checks++; if (b_oaddr !== '0 || b_owdata !== '0 || b_owstrb !== '0 || b_owrite !== 1'b0) begin
            errors++; $display("FAIL reset_out_fields got=%h/%h/%h/%b exp=0", b_oaddr, b_owdata, b_owstrb, b_owrite); end
        checks++; if (a_valid !== 1'b0 || a_ready !== 1'b0) begin
            errors++; $display("FAIL reset_dut0 got valid=%b ready=%b exp=0/0", a_valid, a_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // Read where the slave is ready in the first REQ cycle (dut4).
    task automatic test_read(input logic [AW-1:0] a, input logic [DW-1:0] rd);
        exp_t e;
        @(posedge clk); #1;
        addr = a; write = 1'b0; wdata = '0; wstrb = '0;
        s_rdata = rd; s_error = 1'b0; r4 = 1'b1; v4 = 1'b1;
        q4.push_back('{rd, 1'b0});
        @(posedge clk); @(negedge clk);
        checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL read_out_valid got=%b exp=1", b_valid); end
        checks++; if (b_oaddr !== a) begin errors++; $display("FAIL read_out_addr got=%h exp=%h", b_oaddr, a); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL read_early_ready got=%b exp=0", b_ready); end
        @(posedge clk); @(negedge clk);
        e = q4.pop_front();
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL read_in_ready got=%b exp=1", b_ready); end
        checks++; if (b_rdata !== e.rdata || b_error !== e.err) begin
            errors++; $display("FAIL read_rsp got=%h/%b exp=%h/%b", b_rdata, b_error, e.rdata, e.err); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop got=%b exp=0", b_valid); end
        @(posedge clk); #1 v4 = 1'b0; r4 = 1'b0;
        @(negedge clk);
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL read_ready_pulse got=%b exp=0", b_ready); end
    endtask

    // Write to a slave that stalls 5 cycles (dut0, no watchdog).
    task automatic test_stall();
        exp_t e;
        @(posedge clk); #1;
        addr = 32'h20; write = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'b0101;
        s_rdata = 32'h55; s_error = 1'b1; r0 = 1'b0; v0 = 1'b1;
        q0.push_back('{32'h55, 1'b1});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            // Upstream fields change mid-transaction; the cut must ignore them.
            #1 addr = 32'hFFFF; wdata = 32'h0; wstrb = 4'hF; write = 1'b0;
            @(negedge clk);
            checks++; if (a_valid !== 1'b1 || a_ready !== 1'b0) begin
                errors++; $display("FAIL stall_valid[%0d] got=%b/%b exp=1/0", i, a_valid, a_ready); end
            checks++; if (a_oaddr !== 32'h20 || a_owdata !== 32'hA5A5_A5A5 || a_owstrb !== 4'b0101 || a_owrite !== 1'b1) begin
                errors++; $display("FAIL stall_fields[%0d] got=%h/%h/%h/%b exp=20/a5a5a5a5/5/1", i, a_oaddr, a_owdata, a_owstrb, a_owrite); end
        end
        @(posedge clk); #1 r0 = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_oaddr !== 32'h20) begin
            errors++; $display("FAIL stall_sixth got=%b/%h exp=1/20", a_valid, a_oaddr); end
        @(posedge clk); @(negedge clk);
        e = q0.pop_front();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready got=%b exp=1", a_ready); end
        checks++; if (a_rdata !== e.rdata || a_error !== e.err) begin
            errors++; $display("FAIL stall_rsp got=%h/%b exp=%h/%b", a_rdata, a_error, e.rdata, e.err); end
        @(posedge clk); #1 v0 = 1'b0; r0 = 1'b0; s_error = 1'b0;
        @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_pulse got=%b exp=0", a_ready); end
    endtask

    // Slave never answers: the watchdog completes the transaction with an error (dut4).
    task automatic test_watchdog();
        exp_t e;
        @(posedge clk); #1;
        addr = 32'h30; write = 1'b0; s_rdata = 32'hBAD0_BAD0; s_error = 1'b0; r4 = 1'b0; v4 = 1'b1;
        q4.push_back('{32'h0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (b_valid !== 1'b1 || b_ready !== 1'b0) begin
                errors++; $display("FAIL wd_valid[%0d] got=%b/%b exp=1/0", i, b_valid, b_ready); end
        end
        @(posedge clk); @(negedge clk);
        e = q4.pop_front();
        checks++; if (b_valid !== 1'b0 || b_ready !== 1'b1) begin
            errors++; $display("FAIL wd_expire got valid=%b ready=%b exp=0/1", b_valid, b_ready); end
        checks++; if (b_rdata !== e.rdata || b_error !== e.err) begin
            errors++; $display("FAIL wd_rsp got=%h/%b exp=%h/%b", b_rdata, b_error, e.rdata, e.err); end
        @(posedge clk); #1 v4 = 1'b0;
    endtask

    // Slave answers in the 4th REQ cycle, which is also the watchdog expiry cycle.
    task automatic test_tie();
        exp_t e;
        @(posedge clk); #1;
        addr = 32'h34; write = 1'b0; s_rdata = 32'h1234; s_error = 1'b0; r4 = 1'b0; v4 = 1'b1;
        q4.push_back('{32'h1234, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL tie_valid[%0d] got=%b exp=1", i, b_valid); end
        end
        @(posedge clk); #1 r4 = 1'b1;
        @(negedge clk);
        checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL tie_valid4 got=%b exp=1", b_valid); end
        @(posedge clk); @(negedge clk);
        e = q4.pop_front();
        checks++; if (b_ready !== 1'b1 || b_rdata !== e.rdata || b_error !== e.err) begin
            errors++; $display("FAIL tie_rsp got=%b/%h/%b exp=1/%h/%b", b_ready, b_rdata, b_error, e.rdata, e.err); end
        @(posedge clk); #1 v4 = 1'b0; r4 = 1'b0;
    endtask

    // Three requests with valid held high and an always-ready slave (dut4).
    task automatic test_back_to_back();
        logic [AW-1:0] adrs[3];
        exp_t e;
        int got;
        int last;
        adrs[0] = 32'h100; adrs[1] = 32'h104; adrs[2] = 32'h108;
        got = 0; last = -1;
        @(posedge clk); #1;
        echo = 1'b1; r4 = 1'b1; s_error = 1'b0; write = 1'b0;
        addr = adrs[0]; aq.push_back(adrs[0]);
        q4.push_back('{adrs[0] ^ 32'hF0F0_0000, 1'b0});
        v4 = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (b_valid) begin
                checks++; if (aq.size() == 0 || b_oaddr !== aq[0]) begin
                    errors++; $display("FAIL b2b_addr got=%h exp=%h", b_oaddr, (aq.size() != 0) ? aq[0] : 32'hX); end
            end
            if (b_ready) begin
                if (last >= 0) begin
                    checks++; if (c - last != 3) begin errors++; $display("FAIL b2b_spacing got=%0d exp=3", c - last); end
                end
                last = c;
                checks++;
                if (q4.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_rsp got=%h exp=none", b_rdata);
                end else begin
                    e = q4.pop_front();
                    if (aq.size() != 0) void'(aq.pop_front());
                    if (b_rdata !== e.rdata || b_error !== e.err) begin
                        errors++; $display("FAIL b2b_rsp got=%h/%b exp=%h/%b", b_rdata, b_error, e.rdata, e.err); end
                end
                got++;
                if (got < 3) begin
                    addr = adrs[got]; aq.push_back(adrs[got]);
                    q4.push_back('{adrs[got] ^ 32'hF0F0_0000, 1'b0});
                end
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL b2b_timeout got=%0d exp=3", got); end
        @(posedge clk); #1 v4 = 1'b0; r4 = 1'b0; echo = 1'b0;
        q4.delete(); aq.delete();
    endtask

    // Asynchronous reset in the middle of REQ, then a normal transaction.
    task automatic test_reset_mid();
        @(posedge clk); #1;
        addr = 32'h40; write = 1'b0; r4 = 1'b0; v4 = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (b_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", b_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (b_valid !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got valid=%b ready=%b exp=0/0", b_valid, b_ready); end
        checks++; if (b_oaddr !== '0) begin errors++; $display("FAIL rstmid_addr got=%h exp=0", b_oaddr); end
        v4 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", b_valid); end
        test_read(32'h50, 32'hCAFE_0001);
    endtask

    initial begin
        test_reset();
        test_read(32'h10, 32'hDEAD_BEEF);
        test_stall();
        test_watchdog();
        test_read(32'h38, 32'h0BAD_F00D);
        test_tie();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
